// File: rtl/axi_pkg.sv
// Purpose: shared AXI3 constants for the read-path multiplexer.
//   AXI_BURST_INCR       burst type driven on every AR request
//   AXI_RESP_*           rresp encodings; anything other than OKAY flags an error
//   AXI_LEN_W/SIZE_W     AR length and size field widths
package axi_pkg;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
  localparam int AXI_LEN_W  = 8;
  localparam int AXI_SIZE_W = 3;
endpackage

// File: rtl/axi_rd_mux_rr_arbiter.sv
// Purpose: N-way round-robin arbiter with a registered priority pointer.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   req          per-requester request, already qualified by the caller
//   advance      move the pointer past the current winner
//   grant        one-hot winner (combinational)
//   grant_idx    binary index of the winner (0 when nothing is granted)
module rr_arbiter #(
  parameter int N = 2,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] idx;
  logic             found;

  // Scan from the pointer upwards (wrapping); the first asserted request wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int off = 0; off < N; off++) begin
      idx = IDX_W'((int'(ptr) + off) % N);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  // With N=1 the modulo keeps the pointer at 0 permanently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= IDX_W'((int'(grant_idx) + 1) % N);
    end
  end
endmodule

// File: rtl/axi_rd_mux.sv
// Purpose: N:1 AXI3 read-channel multiplexer. Clients request bursts, a
//   round-robin arbiter feeds a single registered AR stage, each client is
//   limited to MAX_OUTS outstanding bursts, and R beats are routed back by rid.
// Ports:
//   aclk, aresetn            clock, asynchronous active-low reset
//   c_req_*                  per-client burst requests (packed vectors)
//   c_resp_*                 R beats back to clients; valid one-hot by rid, payload broadcast
//   ar*                      AXI3 read address channel towards core-top
//   r*                       AXI3 read data channel from core-top
//   bad_rid                  sticky flag: a beat arrived with rid >= NUM_MST
//   perf_grant, perf_stall   per-client 32-bit counters (packed)
// Configuration: define AXI_RD_MUX_PERF_EN to build the performance counters;
//   otherwise the perf ports are tied to zero.
// Handshakes: every valid/ready pair transfers on a rising edge where both are
//   high; a valid, once raised on AR, holds its payload until ready is seen.
module axi_rd_mux
  import axi_pkg::*;
#(
  parameter int NUM_MST  = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int ID_W     = 4,
  parameter int MAX_OUTS = 2
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [NUM_MST-1:0]          c_req_valid,
  output logic [NUM_MST-1:0]          c_req_ready,
  input  logic [NUM_MST*ADDR_W-1:0]   c_req_addr,
  input  logic [NUM_MST*8-1:0]        c_req_len,
  input  logic [NUM_MST*3-1:0]        c_req_size,
  output logic [NUM_MST-1:0]          c_resp_valid,
  input  logic [NUM_MST-1:0]          c_resp_ready,
  output logic [DATA_W-1:0]           c_resp_data,
  output logic                        c_resp_last,
  output logic                        c_resp_err,
  output logic [ID_W-1:0]             arid,
  output logic [ADDR_W-1:0]           araddr,
  output logic [AXI_LEN_W-1:0]        arlen,
  output logic [AXI_SIZE_W-1:0]       arsize,
  output logic [1:0]                  arburst,
  output logic [1:0]                  arlock,
  output logic [3:0]                  arcache,
  output logic [2:0]                  arprot,
  output logic                        arvalid,
  input  logic                        arready,
  input  logic [ID_W-1:0]             rid,
  input  logic [DATA_W-1:0]           rdata,
  input  logic [1:0]                  rresp,
  input  logic                        rlast,
  input  logic                        rvalid,
  output logic                        rready,
  output logic                        bad_rid,
  output logic [NUM_MST*32-1:0]       perf_grant,
  output logic [NUM_MST*32-1:0]       perf_stall
);
  localparam int IDX_W = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;

  typedef struct packed {
    logic [ADDR_W-1:0]     addr;
    logic [AXI_LEN_W-1:0]  len;
    logic [AXI_SIZE_W-1:0] size;
  } ar_req_t;

  logic [NUM_MST-1:0] elig;
  logic [NUM_MST-1:0] grant;
  logic [NUM_MST-1:0] rid_hit;
  logic [NUM_MST-1:0] r_done;
  logic [IDX_W-1:0]   grant_idx;
  logic               stage_free;
  logic               rid_ok;
  logic [2:0]         outs [NUM_MST];
  ar_req_t            sel_req;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_MST; i++) begin
      elig[i] = c_req_valid[i] && (outs[i] < 3'(MAX_OUTS));
    end
  end

  // The stage can take a new request when empty or being drained this cycle.
  // Gating with aresetn keeps c_req_ready low while reset is asserted.
  assign stage_free = aresetn && (!arvalid || arready);

  rr_arbiter #(.N(NUM_MST)) u_arb (
    .clk       (aclk),
    .rst_n     (aresetn),
    .req       (elig & {NUM_MST{stage_free}}),
    .advance   (|grant),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign c_req_ready = grant;

  always_comb begin
    sel_req = '0;
    for (int i = 0; i < NUM_MST; i++) begin
      if (grant[i]) begin
        sel_req.addr = c_req_addr[i*ADDR_W +: ADDR_W];
        sel_req.len  = c_req_len[i*8 +: 8];
        sel_req.size = c_req_size[i*3 +: 3];
      end
    end
  end

  // AR stage: loads on a grant, otherwise holds until arready drains it.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      arvalid <= 1'b0;
      arid    <= '0;
      araddr  <= '0;
      arlen   <= '0;
      arsize  <= '0;
    end else if (|grant) begin
      arvalid <= 1'b1;
      arid    <= ID_W'(grant_idx);
      araddr  <= sel_req.addr;
      arlen   <= sel_req.len;
      arsize  <= sel_req.size;
    end else if (arready) begin
      arvalid <= 1'b0;
    end
  end

  assign arburst = AXI_BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;

  // R routing. Beats with an id no client owns are drained so the
  // interconnect never stalls on them.
  always_comb begin
    rid_hit = '0;
    for (int i = 0; i < NUM_MST; i++) begin
      rid_hit[i] = (rid == ID_W'(i));
    end
  end

  assign rid_ok       = |rid_hit;
  assign c_resp_valid = rid_hit & {NUM_MST{rvalid}};
  assign rready       = rid_ok ? |(rid_hit & c_resp_ready) : 1'b1;
  assign c_resp_data  = rdata;
  assign c_resp_last  = rlast;
  assign c_resp_err   = (rresp != AXI_RESP_OKAY);
  assign r_done       = rid_hit & {NUM_MST{rvalid & rready & rlast}};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      bad_rid <= 1'b0;
    end else if (rvalid && !rid_ok) begin
      bad_rid <= 1'b1;
    end
  end

  // Outstanding-burst counters; a grant and a completion in the same cycle cancel.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < NUM_MST; i++) outs[i] <= 3'd0;
    end else begin
      for (int i = 0; i < NUM_MST; i++) begin
        case ({grant[i], r_done[i]})
          2'b10:   outs[i] <= outs[i] + 3'd1;
          2'b01:   outs[i] <= outs[i] - 3'd1;
          default: outs[i] <= outs[i];
        endcase
      end
    end
  end

`ifndef SYNTHESIS
  for (genvar g = 0; g < NUM_MST; g++) begin : g_outs_chk
    a_no_underflow: assert property (@(posedge aclk) disable iff (!aresetn)
      !(r_done[g] && outs[g] == 3'd0));
  end
`endif

`ifdef AXI_RD_MUX_PERF_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      perf_grant <= '0;
      perf_stall <= '0;
    end else begin
      for (int i = 0; i < NUM_MST; i++) begin
        if (grant[i]) perf_grant[i*32 +: 32] <= perf_grant[i*32 +: 32] + 32'd1;
        if (c_req_valid[i] && !c_req_ready[i])
          perf_stall[i*32 +: 32] <= perf_stall[i*32 +: 32] + 32'd1;
      end
    end
  end
`else
  assign perf_grant = '0;
  assign perf_stall = '0;
`endif
endmodule

// File: tb/tb_axi_rd_mux.sv
// Bench for axi_rd_mux (NUM_MST=2, MAX_OUTS=2). Inputs change 1 time unit
// after the rising edge; outputs are sampled on the falling edge. Expected AR
// requests are queued when a grant is expected and popped by the AR monitor.
module tb_axi_rd_mux;
  import axi_pkg::*;

  localparam int NUM_MST  = 2;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int ID_W     = 4;
  localparam int MAX_OUTS = 2;
  localparam int EXP_W    = ID_W + ADDR_W + 8 + 3;
`ifdef AXI_RD_MUX_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic                      aclk;
  logic                      aresetn;
  logic [NUM_MST-1:0]        c_req_valid;
  logic [NUM_MST-1:0]        c_req_ready;
  logic [NUM_MST*ADDR_W-1:0] c_req_addr;
  logic [NUM_MST*8-1:0]      c_req_len;
  logic [NUM_MST*3-1:0]      c_req_size;
  logic [NUM_MST-1:0]        c_resp_valid;
  logic [NUM_MST-1:0]        c_resp_ready;
  logic [DATA_W-1:0]         c_resp_data;
  logic                      c_resp_last;
  logic                      c_resp_err;
  logic [ID_W-1:0]           arid;
  logic [ADDR_W-1:0]         araddr;
  logic [7:0]                arlen;
  logic [2:0]                arsize;
  logic [1:0]                arburst;
  logic [1:0]                arlock;
  logic [3:0]                arcache;
  logic [2:0]                arprot;
  logic                      arvalid;
  logic                      arready;
  logic [ID_W-1:0]           rid;
  logic [DATA_W-1:0]         rdata;
  logic [1:0]                rresp;
  logic                      rlast;
  logic                      rvalid;
  logic                      rready;
  logic                      bad_rid;
  logic [NUM_MST*32-1:0]     perf_grant;
  logic [NUM_MST*32-1:0]     perf_stall;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] exp_ent;

  // ---------------- clock / reset ----------------
  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  axi_rd_mux #(
    .NUM_MST(NUM_MST), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .MAX_OUTS(MAX_OUTS)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .c_req_valid(c_req_valid), .c_req_ready(c_req_ready), .c_req_addr(c_req_addr),
    .c_req_len(c_req_len), .c_req_size(c_req_size),
    .c_resp_valid(c_resp_valid), .c_resp_ready(c_resp_ready), .c_resp_data(c_resp_data),
    .c_resp_last(c_resp_last), .c_resp_err(c_resp_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .bad_rid(bad_rid), .perf_grant(perf_grant), .perf_stall(perf_stall)
  );

  // ---------------- AR scoreboard monitor ----------------
  always @(negedge aclk) begin
    if (aresetn && arvalid && arready) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL ar_unexpected: got id=%0d addr=%h len=%0d, expected no request", arid, araddr, arlen);
      end else begin
        exp_ent = exp_q.pop_front();
        if ({arid, araddr, arlen, arsize} !== exp_ent) begin
          tests_failed++;
          $display("FAIL ar_payload: got %h expected %h", {arid, araddr, arlen, arsize}, exp_ent);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle_inputs();
    c_req_valid  = '0;
    c_req_addr   = '0;
    c_req_len    = '0;
    c_req_size   = '0;
    c_resp_ready = '0;
    arready      = 1'b0;
    rid          = '0;
    rdata        = '0;
    rresp        = AXI_RESP_OKAY;
    rlast        = 1'b0;
    rvalid       = 1'b0;
  endtask

  task automatic apply_reset();
    aresetn = 1'b0;
    idle_inputs();
    next_cycle();
    next_cycle();
    aresetn = 1'b1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [7:0] l, input logic [2:0] s);
    c_req_addr[i*ADDR_W +: ADDR_W] = a;
    c_req_len[i*8 +: 8]            = l;
    c_req_size[i*3 +: 3]           = s;
  endtask

  task automatic push_exp(input int i, input logic [31:0] a, input logic [7:0] l, input logic [2:0] s);
    exp_q.push_back({ID_W'(i), a, l, s});
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    aresetn = 1'b0;
    idle_inputs();
    set_req(0, 32'hdead_0000, 8'd5, 3'd2);
    c_req_valid  = 2'b11;
    c_resp_ready = 2'b11;
    arready      = 1'b1;
    rvalid       = 1'b1;
    rid          = 4'd5;
    @(negedge aclk);
    tests_run++;
    if ({arvalid, arid, araddr, arlen, arsize} !== '0) begin
      tests_failed++;
      $display("FAIL reset_ar: got %h expected 0", {arvalid, arid, araddr, arlen, arsize});
    end
    tests_run++;
    if (c_req_ready !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_req_ready: got %b expected 00", c_req_ready);
    end
    tests_run++;
    if ({bad_rid, perf_grant, perf_stall} !== '0) begin
      tests_failed++;
      $display("FAIL reset_flags: bad_rid=%b grant=%h stall=%h expected all 0", bad_rid, perf_grant, perf_stall);
    end
    next_cycle();
    idle_inputs();
    next_cycle();
    aresetn = 1'b1;
  endtask

  task automatic test_single();
    logic [31:0] d;
    apply_reset();
    arready      = 1'b1;
    c_resp_ready = 2'b11;
    set_req(0, 32'h0000_1000, 8'd3, 3'd2);
    c_req_valid = 2'b01;
    push_exp(0, 32'h0000_1000, 8'd3, 3'd2);
    @(negedge aclk);
    tests_run++;
    if (c_req_ready !== 2'b01 || arvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_grant: got ready=%b arvalid=%b expected 01/0", c_req_ready, arvalid);
    end
    next_cycle();
    c_req_valid = 2'b00;
    @(negedge aclk);
    tests_run++;
    if (arvalid !== 1'b1 || arid !== 4'd0 || arlen !== 8'd3) begin
      tests_failed++;
      $display("FAIL single_ar: got arvalid=%b arid=%0d arlen=%0d expected 1/0/3", arvalid, arid, arlen);
    end
    tests_run++;
    if ({arburst, arlock, arcache, arprot} !== {AXI_BURST_INCR, 9'd0}) begin
      tests_failed++;
      $display("FAIL single_ar_const: got %b expected %b", {arburst, arlock, arcache, arprot}, {AXI_BURST_INCR, 9'd0});
    end
    next_cycle();
    for (int b = 0; b < 4; b++) begin
      d      = $urandom;
      rvalid = 1'b1;
      rid    = 4'd0;
      rdata  = d;
      rlast  = (b == 3);
      rresp  = (b == 3) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      @(negedge aclk);
      tests_run++;
      if (c_resp_valid !== 2'b01 || rready !== 1'b1 || c_resp_data !== d ||
          c_resp_last !== (b == 3) || c_resp_err !== (b == 3)) begin
        tests_failed++;
        $display("FAIL single_beat%0d: got valid=%b rready=%b data=%h last=%b err=%b expected 01/1/%h/%b/%b",
                 b, c_resp_valid, rready, c_resp_data, c_resp_last, c_resp_err, d, b == 3, b == 3);
      end
      next_cycle();
    end
    idle_inputs();
    @(negedge aclk);
    tests_run++;
    if (arvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_ar_drained: got arvalid=%b expected 0", arvalid);
    end
    next_cycle();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_rdy;
    apply_reset();
    arready      = 1'b1;
    c_resp_ready = 2'b11;
    set_req(0, 32'h0000_0100, 8'd0, 3'd2);
    set_req(1, 32'h0000_0200, 8'd0, 3'd2);
    for (int t = 0; t < 11; t++) begin
      c_req_valid = (t < 8) ? 2'b11 : 2'b00;
      // The burst granted at t is accepted at t+1 and answered at t+2.
      rvalid = (t >= 2 && t <= 9);
      rid    = ID_W'(t % 2);
      rlast  = 1'b1;
      rdata  = DATA_W'(t);
      exp_rdy = (t < 8) ? ((t % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      if (t < 8) push_exp(t % 2, 32'h0000_0100 * (t % 2 + 1), 8'd0, 3'd2);
      @(negedge aclk);
      tests_run++;
      if (c_req_ready !== exp_rdy) begin
        tests_failed++;
        $display("FAIL rr_grant_t%0d: got %b expected %b", t, c_req_ready, exp_rdy);
      end
      if (t >= 2 && t <= 9) begin
        tests_run++;
        if (c_resp_valid !== ((t % 2 == 0) ? 2'b01 : 2'b10)) begin
          tests_failed++;
          $display("FAIL rr_resp_t%0d: got %b expected one-hot client %0d", t, c_resp_valid, t % 2);
        end
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_ar_backpressure();
    apply_reset();
    arready = 1'b0;
    set_req(0, 32'h0000_2000, 8'd1, 3'd2);
    set_req(1, 32'h0000_3000, 8'd2, 3'd1);
    c_req_valid = 2'b11;
    push_exp(0, 32'h0000_2000, 8'd1, 3'd2);
    @(negedge aclk);
    tests_run++;
    if (c_req_ready !== 2'b01) begin
      tests_failed++;
      $display("FAIL bp_first_grant: got %b expected 01", c_req_ready);
    end
    next_cycle();
    for (int t = 1; t <= 5; t++) begin
      @(negedge aclk);
      tests_run++;
      if (c_req_ready !== 2'b00 || arvalid !== 1'b1 ||
          {arid, araddr, arlen, arsize} !== {4'd0, 32'h0000_2000, 8'd1, 3'd2}) begin
        tests_failed++;
        $display("FAIL bp_hold_t%0d: got ready=%b arvalid=%b ar=%h expected 00/1/%h", t, c_req_ready, arvalid,
                 {arid, araddr, arlen, arsize}, {4'd0, 32'h0000_2000, 8'd1, 3'd2});
      end
      next_cycle();
    end
    arready = 1'b1;
    push_exp(1, 32'h0000_3000, 8'd2, 3'd1);
    @(negedge aclk);
    tests_run++;
    if (c_req_ready !== 2'b10) begin
      tests_failed++;
      $display("FAIL bp_release_grant: got %b expected 10", c_req_ready);
    end
    next_cycle();
    c_req_valid = 2'b00;
    @(negedge aclk);
    tests_run++;
    if (arvalid !== 1'b1 || arid !== 4'd1) begin
      tests_failed++;
      $display("FAIL bp_second_ar: got arvalid=%b arid=%0d expected 1/1", arvalid, arid);
    end
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_outstanding();
    logic [1:0] exp_rdy;
    apply_reset();
    arready      = 1'b1;
    c_resp_ready = 2'b01;
    set_req(0, 32'h0000_4000, 8'd0, 3'd2);
    c_req_valid = 2'b01;
    for (int t = 0; t < 6; t++) begin
      rvalid  = (t == 4);
      rid     = 4'd0;
      rlast   = 1'b1;
      exp_rdy = (t == 0 || t == 1 || t == 5) ? 2'b01 : 2'b00;
      if (exp_rdy == 2'b01) push_exp(0, 32'h0000_4000, 8'd0, 3'd2);
      @(negedge aclk);
      tests_run++;
      if (c_req_ready !== exp_rdy) begin
        tests_failed++;
        $display("FAIL outs_grant_t%0d: got %b expected %b", t, c_req_ready, exp_rdy);
      end
      if (t == 4) begin
        tests_run++;
        if (c_resp_valid !== 2'b01 || rready !== 1'b1) begin
          tests_failed++;
          $display("FAIL outs_resp: got valid=%b rready=%b expected 01/1", c_resp_valid, rready);
        end
      end
      next_cycle();
    end
    idle_inputs();
    arready = 1'b1;
    next_cycle();
    next_cycle();
  endtask

  task automatic test_bad_rid();
    apply_reset();
    rvalid = 1'b1;
    rid    = 4'd5;
    rlast  = 1'b1;
    @(negedge aclk);
    tests_run++;
    if (rready !== 1'b1 || c_resp_valid !== 2'b00 || bad_rid !== 1'b0) begin
      tests_failed++;
      $display("FAIL badrid_drain: got rready=%b valid=%b bad_rid=%b expected 1/00/0", rready, c_resp_valid, bad_rid);
    end
    next_cycle();
    rvalid = 1'b0;
    @(negedge aclk);
    tests_run++;
    if (bad_rid !== 1'b1) begin
      tests_failed++;
      $display("FAIL badrid_set: got %b expected 1", bad_rid);
    end
    rid          = 4'd1;
    c_resp_ready = 2'b01;
    rlast        = 1'b0;
    rvalid       = 1'b1;
    repeat (3) next_cycle();
    @(negedge aclk);
    tests_run++;
    if (bad_rid !== 1'b1 || rready !== 1'b0 || c_resp_valid !== 2'b10) begin
      tests_failed++;
      $display("FAIL badrid_sticky: got bad_rid=%b rready=%b valid=%b expected 1/0/10", bad_rid, rready, c_resp_valid);
    end
    next_cycle();
    idle_inputs();
    aresetn = 1'b0;
    @(negedge aclk);
    tests_run++;
    if (bad_rid !== 1'b0) begin
      tests_failed++;
      $display("FAIL badrid_reset: got %b expected 0", bad_rid);
    end
    next_cycle();
    aresetn = 1'b1;
  endtask

  task automatic test_perf();
    logic [31:0] exp_g0, exp_g1, exp_s0, exp_s1;
    apply_reset();
    arready = 1'b0;
    set_req(0, 32'h0000_5000, 8'd0, 3'd2);
    set_req(1, 32'h0000_6000, 8'd7, 3'd3);
    c_req_valid = 2'b01;
    push_exp(0, 32'h0000_5000, 8'd0, 3'd2);
    next_cycle();
    c_req_valid = 2'b10;
    for (int t = 1; t <= 4; t++) begin
      @(negedge aclk);
      tests_run++;
      if (c_req_ready !== 2'b00) begin
        tests_failed++;
        $display("FAIL perf_stall_ready_t%0d: got %b expected 00", t, c_req_ready);
      end
      next_cycle();
    end
    arready = 1'b1;
    push_exp(1, 32'h0000_6000, 8'd7, 3'd3);
    next_cycle();
    c_req_valid = 2'b00;
    exp_g0 = PERF ? 32'd1 : 32'd0;
    exp_g1 = PERF ? 32'd1 : 32'd0;
    exp_s0 = 32'd0;
    exp_s1 = PERF ? 32'd4 : 32'd0;
    @(negedge aclk);
    tests_run++;
    if (perf_grant !== {exp_g1, exp_g0}) begin
      tests_failed++;
      $display("FAIL perf_grant: got %h expected %h", perf_grant, {exp_g1, exp_g0});
    end
    tests_run++;
    if (perf_stall !== {exp_s1, exp_s0}) begin
      tests_failed++;
      $display("FAIL perf_stall: got %h expected %h", perf_stall, {exp_s1, exp_s0});
    end
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    aresetn = 1'b0;
    idle_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_ar_backpressure();
    test_outstanding();
    test_bad_rid();
    test_perf();
    repeat (3) next_cycle();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL ar_leftover: got %0d queued requests never issued, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
